// File: rtl/mod_pkg.sv
// Shared definitions for the modulation/demodulation segments: reference
// sample levels (Q16.16), default segment count and the FSM state encoding.
package mod_pkg;

  localparam int NUM_SEG_DEF = 10;

  localparam logic signed [31:0] REF_POS = 32'sh0001_0000;
  localparam logic signed [31:0] REF_NEG = 32'shFFFF_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EMIT  = 2'd1,
    ST_GUARD = 2'd2
  } state_t;

  // The reference alternates +1/-1 starting at +1, and a 0 symbol inverts
  // it, so the sample is positive exactly when idx parity differs from bit.
  function automatic logic ref_is_pos(input logic idx_lsb, input logic sym_bit);
    return idx_lsb ^ sym_bit;
  endfunction

endpackage

// File: rtl/mod_ref_rom.sv
// Combinational reference table: maps (sample index, symbol bit) to the
// Q16.16 modulated sample.
module mod_ref_rom
  import mod_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        idx,
  input  logic              sym_bit,
  output logic [DATA_W-1:0] sample
);

  // Only the parity of the index matters for this waveform.
  logic unused_idx_hi;
  assign unused_idx_hi = ^idx[3:1];

  assign sample = ref_is_pos(idx[0], sym_bit) ? DATA_W'(REF_POS) : DATA_W'(REF_NEG);

endmodule

// File: rtl/modulation_segment_ser.sv
// Serialises one symbol bit into NUM_SEG modulated Q16.16 samples.
// Optional macro MODULATION_GUARD_EN appends a zero guard sample per symbol.
module modulation_segment_ser
  import mod_pkg::*;
#(
  parameter int NUM_SEG = NUM_SEG_DEF,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       input_bit,
  input  logic              start,
  output logic [DATA_W-1:0] sample_out,
  output logic [3:0]        sample_idx,
  output logic              valid,
  output logic              last,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_SEG - 1);
`ifdef MODULATION_GUARD_EN
  localparam logic [3:0] GUARD_IDX = 4'(NUM_SEG);
`endif

  state_t            state;
  state_t            state_n;
  logic              bit_q;
  logic              bit_n;
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  logic              accept;
  logic [DATA_W-1:0] rom_sample;

  logic unused_bits;
  assign unused_bits = ^input_bit[31:1];

  assign fsm_state = state;

  // Handshake: a symbol is taken when start is high while the block is idle
  // or presenting its final output of a symbol (last); any other start is
  // dropped without effect. No backpressure exists on the sample stream.
  always_comb begin
    accept  = start && (!busy || last);
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_q;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_n = ST_EMIT;
          cnt_n   = '0;
          bit_n   = input_bit[0];
        end
      end
      ST_EMIT: begin
        if (cnt != LAST_IDX) begin
          cnt_n = cnt + 4'd1;
        end else begin
`ifdef MODULATION_GUARD_EN
          state_n = ST_GUARD;
          cnt_n   = '0;
`else
          cnt_n = '0;
          if (accept) begin
            bit_n = input_bit[0];
          end else begin
            state_n = ST_IDLE;
          end
`endif
        end
      end
      ST_GUARD: begin
        cnt_n = '0;
        if (accept) begin
          state_n = ST_EMIT;
          bit_n   = input_bit[0];
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Looked up with the next index/bit so the outputs can be registered.
  mod_ref_rom #(
    .DATA_W(DATA_W)
  ) u_rom (
    .idx    (cnt_n),
    .sym_bit(bit_n),
    .sample (rom_sample)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_q      <= 1'b0;
      sample_out <= '0;
      sample_idx <= '0;
      valid      <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bit_q <= bit_n;
      busy  <= (state_n != ST_IDLE);
      case (state_n)
        ST_EMIT: begin
          valid      <= 1'b1;
          sample_idx <= cnt_n;
          sample_out <= rom_sample;
`ifdef MODULATION_GUARD_EN
          last       <= 1'b0;
`else
          last       <= (cnt_n == LAST_IDX);
`endif
        end
`ifdef MODULATION_GUARD_EN
        ST_GUARD: begin
          valid      <= 1'b1;
          sample_idx <= GUARD_IDX;
          sample_out <= '0;
          last       <= 1'b1;
        end
`endif
        default: begin
          valid      <= 1'b0;
          sample_idx <= '0;
          sample_out <= '0;
          last       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modulation_segment_ser.sv
// Testbench for modulation_segment_ser: directed scenarios plus random
// start/bit traffic against a queue-based reference of emitted samples.
module tb_modulation_segment_ser;

  localparam int NUM_SEG = 10;
  localparam int DATA_W  = 32;

  // Expected output word: {valid, last, busy, idx[3:0], sample[31:0]}
  localparam int EW = 39;

  logic              clk;
  logic              reset;
  logic [31:0]       input_bit;
  logic              start;
  logic [DATA_W-1:0] sample_out;
  logic [3:0]        sample_idx;
  logic              valid;
  logic              last;
  logic              busy;
  logic [1:0]        fsm_state;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] cur;

  modulation_segment_ser #(
    .NUM_SEG(NUM_SEG),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .input_bit (input_bit),
    .start     (start),
    .sample_out(sample_out),
    .sample_idx(sample_idx),
    .valid     (valid),
    .last      (last),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_sample(input int k, input logic b);
    logic signed [31:0] r;
    r = (k % 2 == 0) ? 32'sd65536 : -32'sd65536;
    return b ? r : -r;
  endfunction

  task automatic push_symbol(input logic b);
    logic lst;
    for (int k = 0; k < NUM_SEG; k++) begin
`ifdef MODULATION_GUARD_EN
      lst = 1'b0;
`else
      lst = (k == NUM_SEG - 1);
`endif
      exp_q.push_back({1'b1, lst, 1'b1, 4'(k), ref_sample(k, b)});
    end
`ifdef MODULATION_GUARD_EN
    exp_q.push_back({1'b1, 1'b1, 1'b1, 4'(NUM_SEG), 32'h0});
`endif
  endtask

  task automatic compare_outputs();
    check("valid",      {63'b0, valid},      {63'b0, cur[38]});
    check("last",       {63'b0, last},       {63'b0, cur[37]});
    check("busy",       {63'b0, busy},       {63'b0, cur[36]});
    check("sample_idx", {60'b0, sample_idx}, {60'b0, cur[35:32]});
    check("sample_out", {32'b0, sample_out}, {32'b0, cur[31:0]});
  endtask

  // driver: present inputs, advance one clock, check registered outputs
  task automatic step(input logic s, input logic [31:0] b);
    logic acc;
    start     = s;
    input_bit = b;
    acc = s && (!cur[36] || cur[37]);
    if (acc) push_symbol(b[0]);
    @(posedge clk);
    cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    start     = 1'b0;
    input_bit = '0;
    exp_q.delete();
    cur = '0;
    #1;
    compare_outputs();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs();
    reset = 1'b1;
  endtask

  logic seq_bits[3] = '{1'b1, 1'b0, 1'b1};

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    input_bit = '0;
    cur       = '0;
    do_reset();

    // single symbol, bit 1
    step(1'b1, 32'h0000_0001);
    repeat (12) step(1'b0, 32'h0);

    // upper bits ignored: behaves as bit 0
    step(1'b1, 32'hFFFF_FFFE);
    repeat (12) step(1'b0, $urandom);

    // start held high, bit changes for each symbol
    for (int j = 0; j < 3 * NUM_SEG; j++) begin
      step(1'b1, {$urandom_range(0, 32'h7FFF_FFFF), seq_bits[j / NUM_SEG]});
    end
    repeat (12) step(1'b0, 32'h0);

    // start mid-symbol is ignored
    step(1'b1, 32'h1);
    repeat (4) step(1'b0, 32'h0);
    step(1'b1, 32'h0);
    repeat (12) step(1'b0, 32'h0);

    // reset mid-symbol abandons it
    step(1'b1, 32'h0);
    repeat (5) step(1'b0, 32'h1);
    do_reset();
    repeat (6) step(1'b0, 32'h1);
    step(1'b1, 32'h1);
    repeat (12) step(1'b0, 32'h0);

    // random traffic
    repeat (400) step($urandom_range(0, 3) == 0, $urandom);
    repeat (14) step(1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
